mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port RAM between the IF fetch path and the MEM
// load/store path. MEM has fixed priority; stuck accesses time out with a sticky bus_err.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        ram_ready,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ack_q;
  logic        mem_ack_q;
  logic        ram_cs_q;
  logic        ram_we_q;
  logic        bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (mem_req) begin
            state_q  <= BUSY_MEM;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            ram_cs_q <= 1'b1;
            ram_we_q <= mem_we;
          end else if (if_req) begin
            state_q  <= BUSY_IF;
            addr_q   <= if_addr;
            ram_cs_q <= 1'b1;
            ram_we_q <= 1'b0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          // ram_ready wins over the timeout on the last allowed cycle
          if (ram_ready || cnt_q == CNT_LAST) begin
            state_q  <= RESP;
            cnt_q    <= '0;
            ram_cs_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (state_q == BUSY_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= ram_ready ? ram_dout : ERR_DATA;
            end else begin
              mem_ack_q <= 1'b1;
              if (!ram_we_q) mem_rdata_q <= ram_ready ? ram_dout : ERR_DATA;
            end
            if (!ram_ready) bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_din   = wdata_q;
  assign bus_err   = bus_err_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_stall = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): expected transactions are queued
// when requests are driven and checked against each ack as it appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
  logic        ram_ready = 1'b0;
  logic        if_stall;
  logic        mem_stall;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ready(ram_ready),
    .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
  );

  typedef struct {
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the RAM: ready is raised in the ready_at-th BUSY cycle (0 = never).
  task automatic wait_ack(input int ready_at, input logic [31:0] dout,
                          output int lat, output int bc);
    exp_t e;
    logic got;
    got = 1'b0;
    lat = 0;
    bc  = 0;
    chk1("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb[0];
    for (int i = 1; i <= 40 && !got; i++) begin
      tick();
      if (if_ack || mem_ack) begin
        got = 1'b1;
        lat = i;
        ram_ready = 1'b0;
      end else begin
        chk1("if_stall", if_stall, if_req);
        chk1("mem_stall", mem_stall, mem_req);
        if (ram_cs) begin
          bc++;
          chk("ram_addr", ram_addr, e.addr);
          chk1("ram_we", ram_we, e.we);
          if (e.we) chk("ram_din", ram_din, e.wdata);
          ram_ready = (bc == ready_at);
          ram_dout  = dout;
        end else begin
          ram_ready = 1'b0;
        end
      end
    end
    chk1("ack_seen", got, 1'b1);
    if (got) begin
      void'(sb.pop_front());
      chk1("ack_mem", mem_ack, e.mem);
      chk1("ack_if", if_ack, !e.mem);
      chk("rdata", e.mem ? mem_rdata : if_rdata, e.rdata);
      chk1("bus_err", bus_err, e.err);
      chk1("ram_cs_resp", ram_cs, 1'b0);
      chk1("stall_at_ack", e.mem ? mem_stall : if_stall, 1'b0);
    end
  endtask

  int lat, bc;

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk1("rst_ram_cs", ram_cs, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_mem_ack", mem_ack, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    rst = 1'b0;

    // ram_ready while idle must be ignored
    ram_ready = 1'b1;
    ram_dout  = 32'hCAFEF00D;
    tick();
    tick();
    chk1("idle_ready_cs", ram_cs, 1'b0);
    chk1("idle_ready_ack", if_ack | mem_ack, 1'b0);
    chk("idle_ready_rdata", if_rdata, 32'h0);
    ram_ready = 1'b0;

    // single fetch, ready in first BUSY cycle
    if_req  = 1'b1;
    if_addr = 32'h40;
    sb.push_back('{mem: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'h0, rdata: 32'h8C010004, err: 1'b0});
    wait_ack(1, 32'h8C010004, lat, bc);
    chk("if_lat", lat, 2);
    chk("if_busy", bc, 1);
    if_req = 1'b0;
    tick();
    chk1("if_ack_pulse", if_ack, 1'b0);
    chk("if_rdata_hold", if_rdata, 32'h8C010004);

    // simultaneous requests: MEM load first, then IF
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h100;
    if_req   = 1'b1;
    if_addr  = 32'h44;
    sb.push_back('{mem: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0, rdata: 32'h12345678, err: 1'b0});
    sb.push_back('{mem: 1'b0, we: 1'b0, addr: 32'h44, wdata: 32'h0, rdata: 32'h00000013, err: 1'b0});
    wait_ack(1, 32'h12345678, lat, bc);
    chk("both_mem_lat", lat, 2);
    chk1("both_if_stall_resp", if_stall, 1'b1);
    mem_req = 1'b0;
    wait_ack(2, 32'h00000013, lat, bc);
    chk("both_if_lat", lat, 4);
    chk("both_if_busy", bc, 2);
    chk("both_mem_rdata_hold", mem_rdata, 32'h12345678);
    if_req = 1'b0;
    tick();

    // store, ready in third BUSY cycle; load data must not move
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h200;
    mem_wdata = 32'hA5A5A5A5;
    sb.push_back('{mem: 1'b1, we: 1'b1, addr: 32'h200, wdata: 32'hA5A5A5A5, rdata: 32'h12345678, err: 1'b0});
    wait_ack(3, 32'hFFFF0000, lat, bc);
    chk("st_lat", lat, 4);
    chk("st_busy", bc, 3);
    mem_req = 1'b0;
    mem_we  = 1'b0;
    tick();
    chk1("st_ram_we_after", ram_we, 1'b0);
    chk1("st_ack_pulse", mem_ack, 1'b0);

    // ready on the timeout cycle is a normal completion
    if_req  = 1'b1;
    if_addr = 32'h80;
    sb.push_back('{mem: 1'b0, we: 1'b0, addr: 32'h80, wdata: 32'h0, rdata: 32'h11112222, err: 1'b0});
    wait_ack(4, 32'h11112222, lat, bc);
    chk("edge_lat", lat, 5);
    chk("edge_busy", bc, 4);
    if_req = 1'b0;
    tick();

    // load that never completes times out
    mem_req  = 1'b1;
    mem_addr = 32'h300;
    sb.push_back('{mem: 1'b1, we: 1'b0, addr: 32'h300, wdata: 32'h0, rdata: 32'hDEADBEEF, err: 1'b1});
    wait_ack(0, 32'h77777777, lat, bc);
    chk("to_lat", lat, 5);
    chk("to_busy", bc, 4);
    mem_req = 1'b0;
    tick();
    chk1("to_err_sticky1", bus_err, 1'b1);

    // a later normal fetch leaves bus_err set
    if_req  = 1'b1;
    if_addr = 32'h84;
    sb.push_back('{mem: 1'b0, we: 1'b0, addr: 32'h84, wdata: 32'h0, rdata: 32'h33334444, err: 1'b1});
    wait_ack(1, 32'h33334444, lat, bc);
    chk("post_to_lat", lat, 2);
    if_req = 1'b0;
    tick();
    chk1("to_err_sticky2", bus_err, 1'b1);
    chk("to_mem_rdata_hold", mem_rdata, 32'hDEADBEEF);

    // reset in the second BUSY cycle aborts the access
    if_req  = 1'b1;
    if_addr = 32'h90;
    tick();
    chk1("abort_cs_b1", ram_cs, 1'b1);
    tick();
    chk1("abort_cs_b2", ram_cs, 1'b1);
    rst    = 1'b1;
    if_req = 1'b0;
    tick();
    chk1("abort_cs_off", ram_cs, 1'b0);
    chk1("abort_no_ack", if_ack, 1'b0);
    chk1("abort_err_clr", bus_err, 1'b0);
    chk("abort_if_rdata", if_rdata, 32'h0);
    chk("abort_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk1("abort_no_ack2", if_ack | mem_ack, 1'b0);
    tick();
    chk1("abort_no_ack3", if_ack | mem_ack, 1'b0);

    if_req  = 1'b1;
    if_addr = 32'h94;
    sb.push_back('{mem: 1'b0, we: 1'b0, addr: 32'h94, wdata: 32'h0, rdata: 32'h55556666, err: 1'b0});
    wait_ack(1, 32'h55556666, lat, bc);
    chk("after_rst_lat", lat, 2);
    if_req = 1'b0;
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
